shift_transfer_controller: RTL
==============================

Name: shift_transfer_controller

Overview:
- Sequences a bidirectional shift register to perform one full-duplex serial transfer per request.
- Accepts a parallel word and a direction over a valid/ready handshake, then shifts it out on `so` while capturing `si`, for exactly N cycles.
- Returns the captured word over a second valid/ready handshake.
- Sits between a parallel-word producer/consumer and a serial link; the shift register is internal to the block.

Parameters:
- N, 4, word width and shift count per transfer (N >= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset; sampled on the clk rising edge.
- tx_valid  input  1  request carries a valid word.
- tx_ready  output  1  controller can accept a request this cycle.
- tx_data  input  N  parallel word to serialise.
- dir  input  1  shift direction, latched at accept:
  - 1 = right: LSB out first, `si` enters at MSB.
  - 0 = left: MSB out first, `si` enters at LSB.
- abort  input  1  cancels an in-progress transfer.
- si  input  1  serial input bit, sampled once per SHIFT cycle.
- so  output  1  serial output bit.
- busy  output  1  high while in SHIFT.
- rx_valid  output  1  rx_data holds a completed transfer.
- rx_ready  input  1  consumer accepts rx_data.
- rx_data  output  N  captured word.

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE, sh=0, cnt=0, dir_q=0, rx_data=0, rx_valid=0. While rst=0: tx_ready=0, so=0, busy=0. Reset overrides every other input, including mid-transfer.
- States: IDLE, SHIFT, DONE. Internal registers: sh[N-1:0], dir_q, cnt (clog2(N) bits).
- tx_ready = (state==IDLE) || (state==DONE && rx_ready). It is combinational and forced 0 in reset.
- Accept (tx_valid && tx_ready at an edge):
  - sh<=tx_data, dir_q<=dir, cnt<=0, state<=SHIFT.
  - If accepted from DONE, the rx handshake completes in the same edge and rx_valid<=0.
- SHIFT, per cycle:
  - so = dir_q ? sh[0] : sh[N-1] (combinational).
  - At the edge: sh<=dir_q ? {si, sh[N-1:1]} : {sh[N-2:0], si}; cnt<=cnt+1.
- After the edge where cnt==N-1: rx_data<=the shifted value, rx_valid<=1, state<=DONE.
- Timing: SHIFT lasts exactly N cycles. rx_valid rises N edges after the accept edge.
- abort=1 in SHIFT: state<=IDLE at the next edge. rx_valid stays 0, rx_data is unchanged, sh is not cleared. abort has no effect in IDLE or DONE.
- Abort on the last SHIFT cycle (cnt==N-1): abort wins, so no rx_valid.
- DONE: rx_valid=1 and rx_data stable until rx_ready=1.
  - rx_ready without a new accept: state<=IDLE, rx_valid<=0.
  - rx_ready with tx_valid: go directly to SHIFT (back-to-back, no idle cycle).
- In SHIFT: tx_valid, tx_data and dir are ignored. A held tx_valid is accepted only when tx_ready next rises.
- so=0 and busy=0 in IDLE and DONE. busy=1 exactly while state==SHIFT.
- rx_valid is never asserted without a completed N-bit transfer.

Test Plan (N=4):
- Right shift: dir=1, tx_data=4'b1011, si=1,1,0,0 over the 4 SHIFT cycles.
  - so=1,1,0,1.
  - Then rx_valid=1 with rx_data=4'b0011, busy=0.
- Left shift: dir=0, tx_data=4'b1000, si=1,0,1,1.
  - so=1,0,0,0.
  - rx_data=4'b1011 after 4 cycles.
- Backpressure: hold rx_ready=0 for 3 cycles after DONE.
  - rx_valid stays 1, rx_data stays stable, tx_ready=0.
  - Then drive rx_ready=1 with tx_valid=1 and tx_data=4'b0101 in the same cycle: rx_valid=0 next cycle, busy=1, first so matches the latched dir.
- Abort: assert abort on the 2nd SHIFT cycle.
  - Next cycle: state IDLE, busy=0, so=0, tx_ready=1.
  - rx_valid never rises and rx_data keeps its prior value.
- Reset mid-transfer: drive rst=0 on the 3rd SHIFT cycle.
  - rx_valid=0, rx_data=0, busy=0, tx_ready=0 while rst=0.
  - tx_ready=1 on the first cycle after rst=1.
- Input stability: during SHIFT, toggle dir and tx_data and hold tx_valid=1.
  - so and rx_data follow the originally latched values.
  - The second request is accepted only when tx_ready next rises, in DONE with rx_ready=1 or in IDLE.

Source files
------------

// File: rtl/shift_transfer_controller.sv
`default_nettype none
// ============================================================================
// Module      : shift_transfer_controller
// Description : Full-duplex serial transfer sequencer. Accepts a parallel word
//               and shift direction over a valid/ready handshake, shifts it
//               out on so while capturing si for exactly N cycles, then
//               returns the captured word over a second valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_transfer_controller #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tx_valid,
  output logic         tx_ready,
  input  logic [N-1:0] tx_data,
  input  logic         dir,
  input  logic         abort,
  input  logic         si,
  output logic         so,
  output logic         busy,
  output logic         rx_valid,
  input  logic         rx_ready,
  output logic [N-1:0] rx_data
);

  localparam int CW = $clog2(N);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [N-1:0]  sh;
  logic          dir_q;
  logic [CW-1:0] cnt;

  logic          accept;
  logic          last_bit;
  logic          shift_en;
  logic [N-1:0]  sh_next;

  // Handshake and shift qualifiers shared by the FSM and the datapath
  always_comb begin
    tx_ready = rst && ((state == ST_IDLE) || ((state == ST_DONE) && rx_ready));
    accept   = tx_valid && tx_ready;
    last_bit = (cnt == CNT_LAST);
    shift_en = (state == ST_SHIFT) && !abort;
    sh_next  = dir_q ? {si, sh[N-1:1]} : {sh[N-2:0], si};
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: abort beats completion on the final shift cycle
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (abort)         state_nxt = ST_IDLE;
        else if (last_bit) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (accept)        state_nxt = ST_SHIFT;
        else if (rx_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: serial bit and busy are only driven while shifting
  always_comb begin
    busy = rst && (state == ST_SHIFT);
    so   = 1'b0;
    if (busy) so = dir_q ? sh[0] : sh[N-1];
  end

  // Datapath: shift register, bit counter and captured result
  always_ff @(posedge clk) begin
    if (!rst) begin
      sh       <= '0;
      dir_q    <= 1'b0;
      cnt      <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      if (accept) begin
        sh    <= tx_data;
        dir_q <= dir;
        cnt   <= '0;
      end else if (shift_en) begin
        sh  <= sh_next;
        cnt <= cnt + CW'(1);
      end

      if (shift_en && last_bit) begin
        rx_data  <= sh_next;
        rx_valid <= 1'b1;
      end else if ((state == ST_DONE) && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
